regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port scheduler for the 32x32 register file. It shares the file's single write port (RegWrite / WriteReg / WriteData) between two writeback requesters: port 0 for ALU results and port 1 for load data. Each requester has a one-entry holding slot with a valid/ready handshake. The block also gives the hazard/stall logic a pending-write query.

## Interface
Parameters:
- DW, 32, data width; must match the register file word width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU writeback request valid.
- req0_ready  out  1  slot 0 can accept this cycle.
- req0_reg  in  AW  destination register.
- req0_data  in  DW  write data.
- req1_valid, req1_ready, req1_reg, req1_data  as port 0, for load writeback.
- RegWrite  out  1  write enable to the register file; registered.
- WriteReg  out  AW  register file write address; registered.
- WriteData  out  DW  register file write data; registered.
- query_reg  in  AW  register number to check.
- query_pending  out  1  combinational; 1 if a write to query_reg is in flight.

## Operation
- Per requester n, state is: slot_full[n], slot_reg[n], slot_data[n].
- A transfer happens when reqn_valid && reqn_ready.
- reqn_ready = !rst && (!slot_full[n] || grant[n]). A full slot being drained this cycle can accept again in the same cycle.
- Writes to register 0 are accepted (handshake completes) but discarded: the slot stays or becomes empty and no RegWrite pulse is produced.
- Arbitration is combinational over the full slots:
  - If exactly one slot is full, that slot is granted.
  - If both are full, the winner depends on the configuration (see below).
  - At most one grant per cycle.
- On a grant:
  - The slot clears, unless refilled by a same-cycle transfer.
  - Next cycle, RegWrite=1, WriteReg=slot_reg and WriteData=slot_data.
- With no grant, RegWrite=0 next cycle; WriteReg and WriteData hold their previous values.
- Ordering:
  - Writes from one requester reach the register file in acceptance order.
  - Across requesters, order is grant order. If both slots target the same register, the later-granted value is the final one.
- query_pending = (query_reg != 0) && ((slot_full[0] && slot_reg[0]==query_reg) || (slot_full[1] && slot_reg[1]==query_reg) || (RegWrite && WriteReg==query_reg)).
- Reset:
  - Both slots empty; RegWrite=0; WriteReg=0; WriteData=0; last_grant=1; req0_ready=req1_ready=0 while rst is high.
  - Contents of full slots are dropped, even mid-operation.
  - A RegWrite pulse already on the outputs in the cycle rst is sampled still completes its write at that edge. Outputs are 0 from the next cycle.

## Timing
- Accept at edge E0.
- Slot full during cycle 1; granted in cycle 1 if uncontended.
- RegWrite high in cycle 2; the register file captures at the edge ending cycle 2.
- Uncontended latency from handshake to write edge: 2 cycles.
- Sustained throughput: 1 write per cycle total.
- With both requesters streaming under round-robin, each requester gets 1 write per 2 cycles; ready toggles accordingly.
- Worst-case wait for a full slot:
  - With WB_RR_EN defined: 1 extra cycle.
  - Without it: slot 1 can starve indefinitely.
- query_pending has zero-cycle latency from query_reg and the current state. It does not include a transfer happening in the same cycle.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - With both slots full, grant the slot opposite to last_grant.
  - last_grant updates on every grant.
  - The first contended grant after reset goes to slot 0.
- WB_RR_EN undefined: fixed priority. Slot 0 always wins; last_grant is not implemented.

## Test plan
- Single write: req0 reg=5, data=0xDEADBEEF, held one cycle → RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF exactly 2 cycles after the handshake edge; a single pulse.
- Zero register: req1 reg=0, data=0x1234 → req1_ready=1, the handshake completes, RegWrite never asserts, and query_pending for reg 0 stays 0.
- Contention with WB_RR_EN defined: both valid every cycle for 6 cycles (req0 reg 1..6, req1 reg 11..16) → WriteReg sequence 1,11,2,12,3,13. Without the macro, the slot-0 sequence 1..6 comes first, and req1_ready stays low after its first accept.
- Back-to-back single requester: req0 valid for 4 consecutive cycles (regs 7,8,9,10) → req0_ready stays 1 and RegWrite is high for 4 consecutive cycles, in order.
- Hazard query: accept req1 reg=9, query_reg=9 → query_pending=1 while the write is in the slot and while RegWrite is high, then 0 once it has been written.
- Reset mid-operation: both slots full, assert rst for 1 cycle → no further RegWrite pulses, all outputs 0 the cycle after, and normal operation resumes on the next request.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler for the 32x32 register file: two one-entry writeback slots (ALU, load) share RegWrite.
// Optional macro WB_RR_EN selects round-robin between full slots; undefined gives slot 0 fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] query_reg,
  output logic          query_pending
);

  logic [1:0]    slotFull;
  logic [1:0]    slotFullNext;
  logic [AW-1:0] slotReg      [2];
  logic [AW-1:0] slotRegNext  [2];
  logic [DW-1:0] slotData     [2];
  logic [DW-1:0] slotDataNext [2];

  logic [1:0]    reqValid;
  logic [1:0]    reqReady;
  logic [1:0]    xfer;
  logic [1:0]    grant;
  logic [AW-1:0] reqReg  [2];
  logic [DW-1:0] reqData [2];
  logic          pickOne;

  logic          regWriteNext;
  logic [AW-1:0] writeRegNext;
  logic [DW-1:0] writeDataNext;

  assign reqValid   = {req1_valid, req0_valid};
  assign reqReg[0]  = req0_reg;
  assign reqReg[1]  = req1_reg;
  assign reqData[0] = req0_data;
  assign reqData[1] = req1_data;

`ifdef WB_RR_EN
  logic lastGrant;

  // Contended slots alternate: serve the one that did not win last time.
  assign pickOne = !lastGrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= 1'b1;
    end else if (|grant) begin
      lastGrant <= grant[1];
    end
  end
`else
  assign pickOne = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    case (slotFull)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pickOne ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // A slot being drained this cycle may be refilled in the same cycle.
  assign reqReady   = rst ? 2'b00 : (~slotFull | grant);
  assign xfer       = reqValid & reqReady;
  assign req0_ready = reqReady[0];
  assign req1_ready = reqReady[1];

  always_comb begin
    slotFullNext  = slotFull;
    slotRegNext   = slotReg;
    slotDataNext  = slotData;
    regWriteNext  = 1'b0;
    writeRegNext  = WriteReg;
    writeDataNext = WriteData;

    if (grant[1]) begin
      regWriteNext  = 1'b1;
      writeRegNext  = slotReg[1];
      writeDataNext = slotData[1];
    end else if (grant[0]) begin
      regWriteNext  = 1'b1;
      writeRegNext  = slotReg[0];
      writeDataNext = slotData[0];
    end

    // Writes to r0 complete the handshake but never occupy the slot.
    for (int n = 0; n < 2; n++) begin
      if (grant[n]) begin
        slotFullNext[n] = 1'b0;
      end
      if (xfer[n]) begin
        slotFullNext[n] = (reqReg[n] != '0);
        slotRegNext[n]  = reqReg[n];
        slotDataNext[n] = reqData[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slotFull  <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      for (int n = 0; n < 2; n++) begin
        slotReg[n]  <= '0;
        slotData[n] <= '0;
      end
    end else begin
      slotFull  <= slotFullNext;
      RegWrite  <= regWriteNext;
      WriteReg  <= writeRegNext;
      WriteData <= writeDataNext;
      for (int n = 0; n < 2; n++) begin
        slotReg[n]  <= slotRegNext[n];
        slotData[n] <= slotDataNext[n];
      end
    end
  end

  // Hazard query sees queued slots and the write currently on the port, not same-cycle transfers.
  assign query_pending = (query_reg != '0) &&
                         ((slotFull[0] && (slotReg[0] == query_reg)) ||
                          (slotFull[1] && (slotReg[1] == query_reg)) ||
                          (RegWrite && (WriteReg == query_reg)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_reg;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_reg;
  logic [DW-1:0] req1_data;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] query_reg;
  logic          query_pending;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .query_reg    (query_reg),
    .query_pending(query_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  // Model: writes accepted but not yet handed to the register file, per requester.
  wr_t           p0[$];
  wr_t           p1[$];
  logic          mRegWrite;
  logic [AW-1:0] mWriteReg;
  logic [DW-1:0] mWriteData;
`ifdef WB_RR_EN
  int            mLast;
`endif

  int            passCnt;
  int            failCnt;
  int            total;
  int            cyc;
  logic [AW-1:0] obsLog[$];
  int            obsCyc[$];
  int            expSeq[6];
  int            i0;
  int            i1;
  logic          rdy0;
  logic          rdy1;
  int            startCyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, advance the model, move past the next edge.
  task automatic step();
    int   served;
    logic er0;
    logic er1;
    logic eq;
    wr_t  w;
    #2;
    served = -1;
    if (p0.size() > 0 && p1.size() > 0) begin
`ifdef WB_RR_EN
      served = (mLast == 1) ? 0 : 1;
`else
      served = 0;
`endif
    end else if (p0.size() > 0) begin
      served = 0;
    end else if (p1.size() > 0) begin
      served = 1;
    end
    er0 = !rst && (p0.size() == 0 || served == 0);
    er1 = !rst && (p1.size() == 0 || served == 1);
    eq  = (query_reg != '0) &&
          ((p0.size() > 0 && p0[0].r == query_reg) ||
           (p1.size() > 0 && p1[0].r == query_reg) ||
           (mRegWrite && mWriteReg == query_reg));
    check("req0_ready", 32'(req0_ready), 32'(er0));
    check("req1_ready", 32'(req1_ready), 32'(er1));
    check("RegWrite", 32'(RegWrite), 32'(mRegWrite));
    check("WriteReg", 32'(WriteReg), 32'(mWriteReg));
    check("WriteData", WriteData, mWriteData);
    check("query_pending", 32'(query_pending), 32'(eq));
    if (RegWrite === 1'b1) begin
      obsLog.push_back(WriteReg);
      obsCyc.push_back(cyc);
    end
    if (rst) begin
      p0.delete();
      p1.delete();
      mRegWrite  = 1'b0;
      mWriteReg  = '0;
      mWriteData = '0;
`ifdef WB_RR_EN
      mLast = 1;
`endif
    end else begin
      mRegWrite = 1'b0;
      if (served == 0) begin
        mRegWrite  = 1'b1;
        mWriteReg  = p0[0].r;
        mWriteData = p0[0].d;
        void'(p0.pop_front());
      end else if (served == 1) begin
        mRegWrite  = 1'b1;
        mWriteReg  = p1[0].r;
        mWriteData = p1[0].d;
        void'(p1.pop_front());
      end
`ifdef WB_RR_EN
      if (served >= 0) mLast = served;
`endif
      if (req0_valid && er0 && req0_reg != '0) begin
        w.r = req0_reg;
        w.d = req0_data;
        p0.push_back(w);
      end
      if (req1_valid && er1 && req1_reg != '0) begin
        w.r = req1_reg;
        w.d = req1_data;
        p1.push_back(w);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    passCnt = 0; failCnt = 0; total = 0; cyc = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    query_reg = '0;
    mRegWrite = 1'b0; mWriteReg = '0; mWriteData = '0;
`ifdef WB_RR_EN
    mLast = 1;
    expSeq = '{1, 11, 2, 12, 3, 13};
`else
    expSeq = '{1, 2, 3, 4, 5, 6};
`endif

    // Reset: outputs cleared, both readies low while rst is high.
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Contention: both requesters stream six writes each.
    obsLog.delete();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 24; c++) begin
      req0_valid = (i0 < 6);
      req0_reg   = 5'(1 + i0);
      req0_data  = $urandom;
      req1_valid = (i1 < 6);
      req1_reg   = 5'(11 + i1);
      req1_data  = $urandom;
      #1;
      rdy0 = req0_ready;
      rdy1 = req1_ready;
`ifndef WB_RR_EN
      if (i1 >= 1 && i0 < 6) check("fixed_req1_starved", 32'(rdy1), 32'd0);
`endif
      step();
      if (req0_valid && rdy0) i0++;
      if (req1_valid && rdy1) i1++;
    end
    idle();
    check("contention_req0_done", 32'(i0), 32'd6);
    check("contention_req1_done", 32'(i1), 32'd6);
    check("contention_count", 32'(obsLog.size()), 32'd12);
    for (int k = 0; k < 6 && k < obsLog.size(); k++)
      check("contention_order", 32'(obsLog[k]), 32'(expSeq[k]));
    repeat (2) step();

    // Single write: pulse exactly two cycles after the handshake.
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("single_ready", 32'(req0_ready), 32'd1);
    step();
    idle();
    check("single_c1_regwrite", 32'(RegWrite), 32'd0);
    step();
    check("single_c2_regwrite", 32'(RegWrite), 32'd1);
    check("single_c2_writereg", 32'(WriteReg), 32'd5);
    check("single_c2_writedata", WriteData, 32'hDEADBEEF);
    step();
    check("single_c3_regwrite", 32'(RegWrite), 32'd0);
    step();

    // Register 0: handshake completes, no write, never pending.
    req1_valid = 1'b1; req1_reg = '0; req1_data = 32'h1234; query_reg = '0;
    #1;
    check("zero_ready", 32'(req1_ready), 32'd1);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      check("zero_regwrite", 32'(RegWrite), 32'd0);
      check("zero_query", 32'(query_pending), 32'd0);
      step();
    end

    // Back-to-back single requester: four consecutive writes in order.
    obsLog.delete();
    obsCyc.delete();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_reg = 5'(7 + k); req0_data = $urandom;
      #1;
      check("b2b_ready", 32'(req0_ready), 32'd1);
      step();
    end
    idle();
    repeat (4) step();
    check("b2b_count", 32'(obsLog.size()), 32'd4);
    for (int k = 0; k < 4 && k < obsLog.size(); k++) begin
      check("b2b_reg", 32'(obsLog[k]), 32'(7 + k));
      check("b2b_consecutive", 32'(obsCyc[k] - obsCyc[0]), 32'(k));
    end

    // Hazard query: pending in the slot and on the port, clear afterwards.
    req1_valid = 1'b1; req1_reg = 5'd9; req1_data = $urandom; query_reg = 5'd9;
    #1;
    check("hazard_same_cycle", 32'(query_pending), 32'd0);
    step();
    idle();
    check("hazard_slot", 32'(query_pending), 32'd1);
    step();
    check("hazard_port_regwrite", 32'(RegWrite), 32'd1);
    check("hazard_port", 32'(query_pending), 32'd1);
    step();
    check("hazard_done", 32'(query_pending), 32'd0);
    step();

    // Reset mid-operation: in-flight pulse completes, remaining slot dropped.
    req0_valid = 1'b1; req0_reg = 5'd20; req0_data = $urandom;
    req1_valid = 1'b1; req1_reg = 5'd21; req1_data = $urandom;
    query_reg = 5'd21;
    step();
    idle();
    step();
    rst = 1'b1;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_inflight_regwrite", 32'(RegWrite), 32'd1);
    check("rst_inflight_reg", 32'(WriteReg), 32'd20);
    step();
    rst = 1'b0;
    check("rst_after_regwrite", 32'(RegWrite), 32'd0);
    check("rst_after_writereg", 32'(WriteReg), 32'd0);
    check("rst_after_writedata", WriteData, 32'd0);
    check("rst_after_query", 32'(query_pending), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_no_pulse", 32'(RegWrite), 32'd0);
    end
    req1_valid = 1'b1; req1_reg = 5'd22; req1_data = 32'hCAFE0022;
    step();
    idle();
    step();
    check("resume_regwrite", 32'(RegWrite), 32'd1);
    check("resume_writereg", 32'(WriteReg), 32'd22);
    check("resume_writedata", WriteData, 32'hCAFE0022);
    step();

    // Random traffic with occasional reset, small register range to force collisions.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      req0_valid = ($urandom_range(0, 9) < 7);
      req0_reg   = 5'($urandom_range(0, 7));
      req0_data  = $urandom;
      req1_valid = ($urandom_range(0, 9) < 6);
      req1_reg   = 5'($urandom_range(0, 7));
      req1_data  = $urandom;
      query_reg  = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
